// File: rtl/mac_accum_stage_if.sv
// mac_accum_stage_if: input beat stream and output result stream of the accumulate stage
interface mac_accum_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 32
);
  logic                  d_valid_i;
  logic                  d_ready_o;
  logic [DATA_WIDTH-1:0] d_data_i;
  logic                  r_valid_o;
  logic                  r_ready_i;
  logic [OUT_WIDTH-1:0]  r_data_o;
  modport master (
    output d_valid_i, d_data_i, r_ready_i,
    input  d_ready_o, r_valid_o, r_data_o
  );
  modport slave (
    input  d_valid_i, d_data_i, r_ready_i,
    output d_ready_o, r_valid_o, r_data_o
  );
endinterface

// File: rtl/mac_accum_stage.sv
// mac_accum_stage: sums len beats, shifts and saturates the sum, emits reps results per job
module mac_accum_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int OUT_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic [CNT_WIDTH-1:0] reps_i,
  input  logic [5:0]           shift_i,
  mac_accum_stage_if.slave     strm,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sat_o
);
  typedef enum logic [1:0] {IDLE, ACC, OUT, DONE} state_t;
  localparam logic [CNT_WIDTH-1:0] cnt_one = 1;
  state_t state, state_n;
  logic signed [ACC_WIDTH-1:0] acc, acc_next, shifted;
  logic [CNT_WIDTH-1:0] len_cnt, rep_cnt, len_q, reps_q;
  logic [5:0] shift_q;
  logic [ACC_WIDTH-OUT_WIDTH:0] top;
  logic [OUT_WIDTH-1:0] sat_val;
  logic d_fire, r_fire, last_beat, last_rep, ovf;
  assign strm.d_ready_o = state == ACC;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign d_fire = strm.d_valid_i & strm.d_ready_o;
  assign r_fire = strm.r_valid_o & strm.r_ready_i;
  assign last_beat = len_cnt == len_q - cnt_one;
  assign last_rep = rep_cnt == reps_q - cnt_one;
  assign acc_next = acc + ACC_WIDTH'($signed(strm.d_data_i));
  assign shifted = acc_next >>> shift_q;
  // the value fits OUT_WIDTH only if every bit above its sign bit equals the sign
  assign top = shifted[ACC_WIDTH-1:OUT_WIDTH-1];
  assign ovf = !(&top || ~|top);
  assign sat_val = !ovf ? shifted[OUT_WIDTH-1:0]
                 : top[ACC_WIDTH-OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                 : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  always_comb begin
    state_n = state;
    if (clear_i) state_n = IDLE;
    else
      case (state)
        IDLE:    if (start_i) state_n = (len_i == '0 || reps_i == '0) ? DONE : ACC;
        ACC:     if (d_fire && last_beat) state_n = OUT;
        OUT:     if (r_fire) state_n = last_rep ? DONE : ACC;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc           <= '0;
      len_cnt       <= '0;
      rep_cnt       <= '0;
      len_q         <= '0;
      reps_q        <= '0;
      shift_q       <= '0;
      strm.r_valid_o <= 1'b0;
      strm.r_data_o  <= '0;
      sat_o         <= 1'b0;
    end else if (clear_i) begin
      acc           <= '0;
      len_cnt       <= '0;
      rep_cnt       <= '0;
      strm.r_valid_o <= 1'b0;
    end else if (state == IDLE && start_i) begin
      len_q   <= len_i;
      reps_q  <= reps_i;
      shift_q <= shift_i;
      acc     <= '0;
      len_cnt <= '0;
      rep_cnt <= '0;
      sat_o   <= 1'b0;
    end else if (d_fire) begin
      acc     <= acc_next;
      len_cnt <= len_cnt + cnt_one;
      if (last_beat) begin
        strm.r_data_o  <= sat_val;
        strm.r_valid_o <= 1'b1;
        sat_o          <= sat_o | ovf;
      end
    end else if (state == OUT && r_fire) begin
      strm.r_valid_o <= 1'b0;
      acc           <= '0;
      len_cnt       <= '0;
      rep_cnt       <= rep_cnt + cnt_one;
    end
  end
endmodule
